// File: rtl/spell_stack_unit_pkg.sv
// Shared SPELL stack constants: op count encoding and stack FSM state codes.
// Imported by the stack engine and the core decoder.
package spell_stack_unit_pkg;

  localparam int unsigned OP_CNT_W = 2;
  localparam logic [OP_CNT_W-1:0] OP_CNT_ILLEGAL = 2'd3;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  function automatic logic op_cnt_illegal(input logic [OP_CNT_W-1:0] cnt);
    return cnt == OP_CNT_ILLEGAL;
  endfunction

endpackage

// File: rtl/spell_stack_unit_regfile.sv
// Stack storage: DEPTH x WIDTH array, two write ports (A wins on address clash),
// two asynchronous read ports, no reset.
module spell_stack_unit_regfile #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a_i,
  input  logic [AW-1:0]    waddr_a_i,
  input  logic [WIDTH-1:0] wdata_a_i,
  input  logic             we_b_i,
  input  logic [AW-1:0]    waddr_b_i,
  input  logic [WIDTH-1:0] wdata_b_i,
  input  logic [AW-1:0]    raddr_0_i,
  output logic [WIDTH-1:0] rdata_0_o,
  input  logic [AW-1:0]    raddr_1_i,
  output logic [WIDTH-1:0] rdata_1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Port B is written first so port A overrides it on the same address.
  always_ff @(posedge clk) begin
    if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
  end

  assign rdata_0_o = mem_q[raddr_0_i];
  assign rdata_1_o = mem_q[raddr_1_i];

endmodule

// File: rtl/spell_stack_unit.sv
// SPELL operand-stack engine: pointer/occupancy tracking, wrap or checked mode,
// sticky overflow/underflow flags and a DEPTH-cycle zeroing sweep after reset or clear.
module spell_stack_unit
  import spell_stack_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter bit          WRAP  = 1'b1,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [OP_CNT_W-1:0] op_pop_i,
  input  logic [OP_CNT_W-1:0] op_push_i,
  input  logic [WIDTH-1:0]    op_top_i,
  input  logic [WIDTH-1:0]    op_below_i,
  output logic                op_err_o,
  output logic [WIDTH-1:0]    top_o,
  output logic [WIDTH-1:0]    below_o,
  output logic [AW-1:0]       sp_o,
  output logic [AW:0]         count_o,
  output logic                err_ovf_o,
  output logic                err_unf_o,
  input  logic                err_clr_i,
  input  logic                sp_load_i,
  input  logic [AW-1:0]       sp_value_i,
  input  logic                clear_i
);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW:0]   count_q, count_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          op_err_q, op_err_d;

  // Level arithmetic is done two bits wider than the pointer so borrows and
  // carries past DEPTH stay visible as signed values.
  logic [AW+1:0] pop_x, push_x, lvl_x, sum_x, thr_x;
  logic          unf_hit, ovf_hit, illegal;
  logic [AW-1:0] nsp;
  logic          do_op;

  logic             we_a, we_b;
  logic [AW-1:0]    waddr_a, waddr_b;
  logic [WIDTH-1:0] wdata_a;

  always_comb begin
    pop_x   = (AW+2)'(op_pop_i);
    push_x  = (AW+2)'(op_push_i);
    lvl_x   = WRAP ? (AW+2)'(sp_q) : (AW+2)'(count_q);
    sum_x   = lvl_x - pop_x + push_x;
    thr_x   = WRAP ? (AW+2)'(DEPTH - 1) : (AW+2)'(DEPTH);
    unf_hit = pop_x > lvl_x;
    ovf_hit = $signed(sum_x) > $signed(thr_x);
    illegal = op_cnt_illegal(op_pop_i) || op_cnt_illegal(op_push_i);
    nsp     = sp_q - AW'(op_pop_i) + AW'(op_push_i);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sp_d      = sp_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q & ~err_clr_i;
    err_unf_d = err_unf_q & ~err_clr_i;
    op_err_d  = 1'b0;
    do_op     = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (clear_i) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + AW'(1);
          if (idx_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
        end
      end
      default: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          idx_d     = '0;
          sp_d      = '0;
          count_d   = '0;
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
        end else if (sp_load_i) begin
          sp_d    = sp_value_i;
          count_d = {1'b0, sp_value_i};
        end else if (op_valid_i) begin
          if (illegal) begin
            op_err_d = 1'b1;
          end else if (!WRAP && unf_hit) begin
            err_unf_d = 1'b1;
            op_err_d  = 1'b1;
          end else if (!WRAP && ovf_hit) begin
            err_ovf_d = 1'b1;
            op_err_d  = 1'b1;
          end else begin
            do_op   = 1'b1;
            sp_d    = nsp;
            count_d = WRAP ? {1'b0, nsp} : sum_x[AW:0];
            // In wrap mode the flags only record that the pointer wrapped.
            if (WRAP && unf_hit) err_unf_d = 1'b1;
            if (WRAP && ovf_hit) err_ovf_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    if (state_q == ST_CLEAR) begin
      we_a    = 1'b1;
      waddr_a = idx_q;
      wdata_a = '0;
    end else begin
      we_a    = do_op && (op_push_i != '0);
      waddr_a = nsp - AW'(1);
      wdata_a = op_top_i;
    end
    we_b    = (state_q == ST_IDLE) && do_op && (op_push_i == 2'd2);
    waddr_b = nsp - AW'(2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      idx_q     <= '0;
      sp_q      <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sp_q      <= sp_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      op_err_q  <= op_err_d;
    end
  end

  spell_stack_unit_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .we_a_i    (we_a),
    .waddr_a_i (waddr_a),
    .wdata_a_i (wdata_a),
    .we_b_i    (we_b),
    .waddr_b_i (waddr_b),
    .wdata_b_i (op_below_i),
    .raddr_0_i (sp_q - AW'(1)),
    .rdata_0_o (top_o),
    .raddr_1_i (sp_q - AW'(2)),
    .rdata_1_o (below_o)
  );

  assign op_ready_o = (state_q == ST_IDLE);
  assign op_err_o   = op_err_q;
  assign sp_o       = sp_q;
  assign count_o    = count_q;
  assign err_ovf_o  = err_ovf_q;
  assign err_unf_o  = err_unf_q;

endmodule

// File: tb/tb_spell_stack_unit.sv
// Bench for spell_stack_unit: checked (WRAP=0) and wrapping (WRAP=1) instances share stimulus
// and are compared against an integer stack model after every clock edge.
module tb_spell_stack_unit;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          op_valid = 1'b0;
  logic [1:0]    op_pop = '0;
  logic [1:0]    op_push = '0;
  logic [W-1:0]  op_top = '0;
  logic [W-1:0]  op_below = '0;
  logic          err_clr = 1'b0;
  logic          sp_load = 1'b0;
  logic [AW-1:0] sp_value = '0;
  logic          clear = 1'b0;

  logic          op_ready_s [2];
  logic          op_err_s   [2];
  logic [W-1:0]  top_s      [2];
  logic [W-1:0]  below_s    [2];
  logic [AW-1:0] sp_s       [2];
  logic [AW:0]   count_s    [2];
  logic          ovf_s      [2];
  logic          unf_s      [2];

  spell_stack_unit #(.WIDTH(W), .DEPTH(D), .WRAP(1'b0)) u_dut_chk (
    .clk (clk), .rst_n (rst_n), .op_valid_i (op_valid), .op_ready_o (op_ready_s[0]),
    .op_pop_i (op_pop), .op_push_i (op_push), .op_top_i (op_top), .op_below_i (op_below),
    .op_err_o (op_err_s[0]), .top_o (top_s[0]), .below_o (below_s[0]), .sp_o (sp_s[0]),
    .count_o (count_s[0]), .err_ovf_o (ovf_s[0]), .err_unf_o (unf_s[0]),
    .err_clr_i (err_clr), .sp_load_i (sp_load), .sp_value_i (sp_value), .clear_i (clear)
  );

  spell_stack_unit #(.WIDTH(W), .DEPTH(D), .WRAP(1'b1)) u_dut_wrap (
    .clk (clk), .rst_n (rst_n), .op_valid_i (op_valid), .op_ready_o (op_ready_s[1]),
    .op_pop_i (op_pop), .op_push_i (op_push), .op_top_i (op_top), .op_below_i (op_below),
    .op_err_o (op_err_s[1]), .top_o (top_s[1]), .below_o (below_s[1]), .sp_o (sp_s[1]),
    .count_o (count_s[1]), .err_ovf_o (ovf_s[1]), .err_unf_o (unf_s[1]),
    .err_clr_i (err_clr), .sp_load_i (sp_load), .sp_value_i (sp_value), .clear_i (clear)
  );

  // Reference model: index 0 = checked mode, index 1 = wrap mode.
  int m_sp [2];
  int m_cnt [2];
  bit m_ovf [2];
  bit m_unf [2];
  bit m_err [2];
  int m_mem [2][D];
  int m_clr;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_clr = D;
    for (int w = 0; w < 2; w++) begin
      m_sp[w] = 0; m_cnt[w] = 0; m_ovf[w] = 0; m_unf[w] = 0; m_err[w] = 0;
      for (int i = 0; i < D; i++) m_mem[w][i] = 0;
    end
  endtask

  task automatic model_op(input int w);
    int p, q, nsp;
    p = int'(op_pop);
    q = int'(op_push);
    if (p == 3 || q == 3) begin
      m_err[w] = 1;
    end else if (w == 0 && p > m_cnt[w]) begin
      m_unf[w] = 1; m_err[w] = 1;
    end else if (w == 0 && m_cnt[w] - p + q > D) begin
      m_ovf[w] = 1; m_err[w] = 1;
    end else begin
      if (w == 1 && m_sp[w] - p < 0) m_unf[w] = 1;
      if (w == 1 && m_sp[w] - p + q > D - 1) m_ovf[w] = 1;
      nsp = (m_sp[w] - p + q + D) % D;
      if (q >= 1) m_mem[w][(nsp - 1 + D) % D] = int'(op_top);
      if (q == 2) m_mem[w][(nsp - 2 + D) % D] = int'(op_below);
      m_cnt[w] = (w == 0) ? m_cnt[w] - p + q : nsp;
      m_sp[w] = nsp;
    end
  endtask

  // Applies the current inputs to the model as of the coming rising edge.
  task automatic model_edge();
    if (m_clr > 0) begin
      for (int w = 0; w < 2; w++) begin
        m_err[w] = 0;
        if (err_clr) begin m_ovf[w] = 0; m_unf[w] = 0; end
      end
      m_clr = clear ? D : m_clr - 1;
    end else if (clear) begin
      model_reset();
    end else begin
      for (int w = 0; w < 2; w++) begin
        m_err[w] = 0;
        if (err_clr) begin m_ovf[w] = 0; m_unf[w] = 0; end
        if (sp_load) begin
          m_sp[w] = int'(sp_value); m_cnt[w] = int'(sp_value);
        end else if (op_valid) begin
          model_op(w);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("w%0d ready", w), 32'(op_ready_s[w]), 32'(m_clr == 0));
      chk($sformatf("w%0d sp", w), 32'(sp_s[w]), 32'(m_sp[w]));
      chk($sformatf("w%0d count", w), 32'(count_s[w]), 32'(m_cnt[w]));
      chk($sformatf("w%0d err_ovf", w), 32'(ovf_s[w]), 32'(m_ovf[w]));
      chk($sformatf("w%0d err_unf", w), 32'(unf_s[w]), 32'(m_unf[w]));
      chk($sformatf("w%0d op_err", w), 32'(op_err_s[w]), 32'(m_err[w]));
      if (m_clr == 0) begin
        chk($sformatf("w%0d top", w), 32'(top_s[w]), 32'(m_mem[w][(m_sp[w] + D - 1) % D]));
        chk($sformatf("w%0d below", w), 32'(below_s[w]), 32'(m_mem[w][(m_sp[w] + D - 2) % D]));
      end
    end
  endtask

  task automatic edge_keep();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    edge_keep();
    op_valid = 1'b0; clear = 1'b0; sp_load = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic do_op(input int p, input int q, input int t, input int b);
    op_valid = 1'b1; op_pop = 2'(p); op_push = 2'(q); op_top = W'(t); op_below = W'(b);
    step();
  endtask

  task automatic do_load(input int v, input bit clr_flags);
    sp_load = 1'b1; sp_value = AW'(v); err_clr = clr_flags;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  // Counts cycles with op_ready low (bounded) while inputs stay as set.
  task automatic sweep_measure(input string tag);
    int low;
    low = 0;
    while (op_ready_s[0] === 1'b0 && low < 40) begin
      low++;
      edge_keep();
    end
    chk({tag, " ready-low cycles"}, 32'(low), 32'(D));
    op_valid = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    op_valid = 1'b1; op_pop = 2'd0; op_push = 2'd1; op_top = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    sweep_measure("reset");
    chk("reset top", 32'(top_s[0]), 32'h0);
    chk("reset below", 32'(below_s[1]), 32'h0);
    chk("reset sp", 32'(sp_s[0]), 32'h0);

    do_op(0, 1, 'h11, 0);
    do_op(0, 1, 'h22, 0);
    do_op(0, 2, 'h44, 'h33);
    for (int w = 0; w < 2; w++) begin
      chk("push2 sp", 32'(sp_s[w]), 32'd4);
      chk("push2 top", 32'(top_s[w]), 32'h44);
      chk("push2 below", 32'(below_s[w]), 32'h33);
      chk("push2 count", 32'(count_s[w]), 32'd4);
    end

    do_load(1, 1'b0);
    do_op(2, 1, 'h77, 0);
    chk("unf op_err", 32'(op_err_s[0]), 32'd1);
    chk("unf flag", 32'(unf_s[0]), 32'd1);
    chk("unf sp kept", 32'(sp_s[0]), 32'd1);
    chk("unf top kept", 32'(top_s[0]), 32'h11);
    chk("wrap unf no op_err", 32'(op_err_s[1]), 32'd0);
    err_clr = 1'b1;
    step();
    chk("err_clr unf", 32'(unf_s[0]), 32'd0);

    do_load(0, 1'b1);
    for (int i = 0; i < D; i++) do_op(0, 1, i + 'h40, 0);
    chk("full count", 32'(count_s[0]), 32'd32);
    chk("full sp", 32'(sp_s[0]), 32'd0);
    do_op(0, 1, 'hEE, 0);
    chk("ovf op_err", 32'(op_err_s[0]), 32'd1);
    chk("ovf flag", 32'(ovf_s[0]), 32'd1);
    do_op(1, 1, 'hAA, 0);
    chk("full replace op_err", 32'(op_err_s[0]), 32'd0);
    chk("full replace top", 32'(top_s[0]), 32'hAA);

    do_load(0, 1'b1);
    do_op(1, 0, 0, 0);
    chk("wrap pop sp", 32'(sp_s[1]), 32'd31);
    chk("wrap pop unf", 32'(unf_s[1]), 32'd1);
    chk("wrap pop op_err", 32'(op_err_s[1]), 32'd0);
    do_op(0, 2, 'hB1, 'hB0);
    chk("wrap push2 sp", 32'(sp_s[1]), 32'd1);
    chk("wrap push2 ovf", 32'(ovf_s[1]), 32'd1);
    do_op(3, 0, 0, 0);
    do_op(1, 3, 0, 0);

    clear = 1'b1; sp_load = 1'b1; sp_value = 5'd7;
    op_valid = 1'b1; op_pop = 2'd0; op_push = 2'd1; op_top = 8'h99;
    step();
    chk("clear sp", 32'(sp_s[1]), 32'd0);
    chk("clear op_err", 32'(op_err_s[0]), 32'd0);
    for (int i = 0; i < 5; i++) step();
    do_reset();
    sweep_measure("mid-sweep reset");

    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      err_clr = ($urandom_range(0, 9) == 0);
      if (r < 2) begin
        clear = 1'b1;
      end else if (r < 8) begin
        sp_load = 1'b1; sp_value = AW'($urandom_range(0, D - 1));
      end
      op_valid = ($urandom_range(0, 4) != 0);
      op_pop = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op_push = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op_top = W'($urandom);
      op_below = W'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
